// File: rtl/mac_result_serializer.sv
// Streams one packed MAC result as 1-3 OUT_WIDTH beats, least-significant first,
// over a valid/ready bus, tagging each beat with its index and a last flag.
module mac_result_serializer #(
  parameter int OUT_WIDTH    = 16,
  parameter int INT_WIDTH    = 64,
  parameter int BEATS_SINGLE = 1,
  parameter int BEATS_DUAL   = 2,
  parameter int BEATS_QUAD   = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INT_WIDTH-1:0] in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic [1:0]           out_idx,
  output logic                 mode_err
);

  // Precision-mode encoding shared with the MAC block; 2'b11 is unused.
  localparam logic [1:0] MAC_SINGLE = 2'b00;
  localparam logic [1:0] MAC_DUAL   = 2'b01;
  localparam logic [1:0] MAC_QUAD   = 2'b10;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state, state_nx;
  logic [INT_WIDTH-1:0]   hold;
  logic [1:0]             counter;
  logic [1:0]             total;
  logic [1:0]             total_nx;
  logic                   mode_legal;
  logic                   in_xfer;
  logic                   out_xfer;
  logic [OUT_WIDTH-1:0]   beat_sel;
  logic                   hold_unused;

  // Bits above the widest (quad) payload can never be emitted.
  assign hold_unused = ^hold[INT_WIDTH-1:3*OUT_WIDTH];

  // Mode decode: beat total for the offered word and whether it is legal.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    mode_legal = 1'b1;
    total_nx   = 2'(BEATS_SINGLE);
    case (in_mode)
      MAC_SINGLE: total_nx = 2'(BEATS_SINGLE);
      MAC_DUAL:   total_nx = 2'(BEATS_DUAL);
      MAC_QUAD:   total_nx = 2'(BEATS_QUAD);
      default:    mode_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (counter)
      2'd0:    beat_sel = hold[0 +: OUT_WIDTH];
      2'd1:    beat_sel = hold[OUT_WIDTH +: OUT_WIDTH];
      default: beat_sel = hold[2*OUT_WIDTH +: OUT_WIDTH];
    endcase
  end

  // Beat outputs decode straight from state so reset clears them immediately.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_idx   = 2'd0;
    out_last  = 1'b0;
    if (state == SEND) begin
      out_valid = 1'b1;
      out_data  = beat_sel;
      out_idx   = counter;
      out_last  = (counter == total - 2'd1);
    end
  end

  // Last-beat handover is combinational so back-to-back results have no bubble.
  assign in_ready = (state == IDLE) || (state == SEND && out_ready && out_last);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_xfer && mode_legal) state_nx = SEND;
      SEND: if (out_xfer && out_last)  state_nx = (in_xfer && mode_legal) ? SEND : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // NOTE: the hold register is a plain flop bank, not a memory, so it is reset
  // along with the rest of the datapath.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold     <= '0;
      counter  <= 2'd0;
      total    <= 2'd0;
      mode_err <= 1'b0;
    end else begin
      mode_err <= in_xfer && !mode_legal;
      if (in_xfer && mode_legal) begin
        hold    <= in_data;
        total   <= total_nx;
        counter <= 2'd0;
      end else if (out_xfer && !out_last) begin
        counter <= counter + 2'd1;
      end
    end
  end

endmodule
